// File: rtl/alu_issue.sv
// Decode/issue stage: decodes an RV32I word, forwards from EX/MEM and MEM/WB,
// and registers the ALU operands, operation code, pc+4 and status flags.
module alu_issue #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [31:0]              instr,
    input  logic [8:0]               pc,
    input  logic [DATA_WIDTH-1:0]    rs1_data,
    input  logic [DATA_WIDTH-1:0]    rs2_data,
    input  logic                     exmem_regwrite,
    input  logic [4:0]               exmem_rd,
    input  logic [DATA_WIDTH-1:0]    exmem_result,
    input  logic                     memwb_regwrite,
    input  logic [4:0]               memwb_rd,
    input  logic [DATA_WIDTH-1:0]    memwb_result,
    input  logic                     stall,
    input  logic                     flush,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic [8:0]               Pc4,
    output logic                     out_valid,
    output logic                     illegal
);

    localparam logic [OPCODE_LENGTH-1:0] OP_AND  = OPCODE_LENGTH'(4'b0000);
    localparam logic [OPCODE_LENGTH-1:0] OP_XOR  = OPCODE_LENGTH'(4'b0001);
    localparam logic [OPCODE_LENGTH-1:0] OP_SUB  = OPCODE_LENGTH'(4'b0010);
    localparam logic [OPCODE_LENGTH-1:0] OP_OR   = OPCODE_LENGTH'(4'b0011);
    localparam logic [OPCODE_LENGTH-1:0] OP_ADD  = OPCODE_LENGTH'(4'b0100);
    localparam logic [OPCODE_LENGTH-1:0] OP_BGE  = OPCODE_LENGTH'(4'b0101);
    localparam logic [OPCODE_LENGTH-1:0] OP_BNE  = OPCODE_LENGTH'(4'b0110);
    localparam logic [OPCODE_LENGTH-1:0] OP_SRAI = OPCODE_LENGTH'(4'b0111);
    localparam logic [OPCODE_LENGTH-1:0] OP_BEQ  = OPCODE_LENGTH'(4'b1000);
    localparam logic [OPCODE_LENGTH-1:0] OP_SLLI = OPCODE_LENGTH'(4'b1001);
    localparam logic [OPCODE_LENGTH-1:0] OP_LUI  = OPCODE_LENGTH'(4'b1010);
    localparam logic [OPCODE_LENGTH-1:0] OP_SRLI = OPCODE_LENGTH'(4'b1100);
    localparam logic [OPCODE_LENGTH-1:0] OP_BLT  = OPCODE_LENGTH'(4'b1101);
    localparam logic [OPCODE_LENGTH-1:0] OP_SLT  = OPCODE_LENGTH'(4'b1110);
    localparam logic [OPCODE_LENGTH-1:0] OP_JAL  = OPCODE_LENGTH'(4'b1111);

    // Handshake: in_valid qualifies instr/pc/rs*_data for one cycle; there is no
    // ready. While stall=1 (and flush=0) the input is ignored and the upstream
    // stage must hold it; flush overrides stall and injects a bubble.

    function automatic logic [DATA_WIDTH-1:0] fwd(
        input logic [4:0]            rs,
        input logic [DATA_WIDTH-1:0] rf_data,
        input logic                  ex_we,
        input logic [4:0]            ex_rd,
        input logic [DATA_WIDTH-1:0] ex_res,
        input logic                  wb_we,
        input logic [4:0]            wb_rd,
        input logic [DATA_WIDTH-1:0] wb_res
    );
        if (ex_we && (ex_rd == rs) && (rs != 5'd0)) return ex_res;
        else if (wb_we && (wb_rd == rs) && (rs != 5'd0)) return wb_res;
        else return rf_data;
    endfunction

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic                  bit30;
    logic [DATA_WIDTH-1:0] rs1_val;
    logic [DATA_WIDTH-1:0] rs2_val;
    logic [DATA_WIDTH-1:0] imm_i;
    logic [DATA_WIDTH-1:0] imm_s;
    logic [DATA_WIDTH-1:0] imm_u;

    assign opcode  = instr[6:0];
    assign funct3  = instr[14:12];
    assign bit30   = instr[30];
    assign rs1_val = fwd(instr[19:15], rs1_data, exmem_regwrite, exmem_rd, exmem_result,
                         memwb_regwrite, memwb_rd, memwb_result);
    assign rs2_val = fwd(instr[24:20], rs2_data, exmem_regwrite, exmem_rd, exmem_result,
                         memwb_regwrite, memwb_rd, memwb_result);
    assign imm_i   = DATA_WIDTH'($signed(instr[31:20]));
    assign imm_s   = DATA_WIDTH'($signed({instr[31:25], instr[11:7]}));
    assign imm_u   = DATA_WIDTH'($signed({instr[31:12], 12'b0}));

    logic [OPCODE_LENGTH-1:0] dec_op;
    logic [DATA_WIDTH-1:0]    dec_b;
    logic                     dec_illegal;

    always_comb begin
        dec_op      = OP_AND;
        dec_b       = '0;
        dec_illegal = 1'b0;
        case (opcode)
            7'b0110011: begin
                dec_b = rs2_val;
                case (funct3)
                    3'b000:  dec_op = bit30 ? OP_SUB : OP_ADD;
                    3'b111:  dec_op = OP_AND;
                    3'b110:  dec_op = OP_OR;
                    3'b100:  dec_op = OP_XOR;
                    3'b010:  dec_op = OP_SLT;
                    default: dec_illegal = 1'b1;
                endcase
            end
            7'b0010011: begin
                // SRAI keeps instr[30] in the immediate; the ALU masks it off.
                dec_b = imm_i;
                case (funct3)
                    3'b000:  dec_op = OP_ADD;
                    3'b010:  dec_op = OP_SLT;
                    3'b111:  dec_op = OP_AND;
                    3'b110:  dec_op = OP_OR;
                    3'b100:  dec_op = OP_XOR;
                    3'b001:  dec_op = OP_SLLI;
                    3'b101:  dec_op = bit30 ? OP_SRAI : OP_SRLI;
                    default: dec_illegal = 1'b1;
                endcase
            end
            7'b0000011: begin
                dec_op = OP_ADD;
                dec_b  = imm_i;
            end
            7'b0100011: begin
                dec_op = OP_ADD;
                dec_b  = imm_s;
            end
            7'b1100011: begin
                dec_b = rs2_val;
                case (funct3)
                    3'b000:  dec_op = OP_BEQ;
                    3'b001:  dec_op = OP_BNE;
                    3'b100:  dec_op = OP_BLT;
                    3'b101:  dec_op = OP_BGE;
                    default: dec_illegal = 1'b1;
                endcase
            end
            7'b0110111: begin
                dec_op = OP_LUI;
                dec_b  = imm_u;
            end
            7'b1101111: dec_op = OP_JAL;
            7'b1100111: begin
                dec_op = OP_JAL;
                dec_b  = imm_i;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    logic [DATA_WIDTH-1:0]    src_a_d, src_a_q;
    logic [DATA_WIDTH-1:0]    src_b_d, src_b_q;
    logic [OPCODE_LENGTH-1:0] op_d, op_q;
    logic [8:0]               pc4_d, pc4_q;
    logic                     valid_d, valid_q;
    logic                     illegal_d, illegal_q;

    always_comb begin
        src_a_d   = '0;
        src_b_d   = '0;
        op_d      = OP_AND;
        pc4_d     = 9'd0;
        valid_d   = 1'b0;
        illegal_d = 1'b0;
        if (flush) begin
            // bubble: defaults above
        end else if (stall) begin
            src_a_d   = src_a_q;
            src_b_d   = src_b_q;
            op_d      = op_q;
            pc4_d     = pc4_q;
            valid_d   = valid_q;
            illegal_d = illegal_q;
        end else if (in_valid) begin
            valid_d   = 1'b1;
            pc4_d     = pc + 9'd4;
            illegal_d = dec_illegal;
            if (!dec_illegal) begin
                src_a_d = rs1_val;
                src_b_d = dec_b;
                op_d    = dec_op;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_a_q   <= '0;
            src_b_q   <= '0;
            op_q      <= '0;
            pc4_q     <= 9'd0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            src_a_q   <= src_a_d;
            src_b_q   <= src_b_d;
            op_q      <= op_d;
            pc4_q     <= pc4_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
        end
    end

    assign SrcA      = src_a_q;
    assign SrcB      = src_b_q;
    assign Operation = op_q;
    assign Pc4       = pc4_q;
    assign out_valid = valid_q;
    assign illegal   = illegal_q;

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
Parameters:
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, operand and result width.
REQ-002 The block SHALL have parameter OPCODE_LENGTH, default 4, width of the Operation output.

Ports:
REQ-003 The block SHALL have port clk, input, 1 bit, single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, asynchronous, active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit, instr/pc/rs data valid this cycle.
REQ-006 The block SHALL have port instr, input, 32 bits, RV32I instruction word.
REQ-007 The block SHALL have port pc, input, 9 bits, instruction address.
REQ-008 The block SHALL have ports rs1_data and rs2_data, input, DATA_WIDTH each, register-file read data.
REQ-009 The block SHALL have ports exmem_regwrite (1 bit), exmem_rd (5 bits) and exmem_result (DATA_WIDTH), all inputs, the EX/MEM forwarding source.
REQ-010 The block SHALL have ports memwb_regwrite (1 bit), memwb_rd (5 bits) and memwb_result (DATA_WIDTH), all inputs, the MEM/WB forwarding source.
REQ-011 The block SHALL have ports stall and flush, input, 1 bit each, pipeline control.
REQ-012 The block SHALL have ports SrcA and SrcB, output, DATA_WIDTH each, registered ALU operands.
REQ-013 The block SHALL have port Operation, output, OPCODE_LENGTH, registered ALU operation code.
REQ-014 The block SHALL have port Pc4, output, 9 bits, registered pc+4 (modulo 512).
REQ-015 The block SHALL have ports out_valid and illegal, output, 1 bit each, registered.

Function
REQ-016 The block SHALL decode an instruction combinationally and register the result, giving 1-cycle latency from in_valid to out_valid.
REQ-017 Operation codes SHALL be: AND 0000, XOR 0001, SUB 0010, OR 0011, ADD 0100, BGE 0101, BNE 0110, SRAI 0111, BEQ 1000, SLLI 1001, LUI 1010, SRLI 1100, BLT 1101, SLT 1110, JAL/JALR 1111.
REQ-018 R-type (0110011) SHALL decode as: funct3 000 -> ADD when instr[30]=0, SUB when instr[30]=1; 111 AND; 110 OR; 100 XOR; 010 SLT; SrcB=rs2.
REQ-019 I-type ALU (0010011) SHALL decode as: 000 ADD; 010 SLT; 111 AND; 110 OR; 100 XOR; 001 SLLI; 101 SRLI when instr[30]=0, SRAI when instr[30]=1.
REQ-020 I-type ALU SrcB SHALL be the sign-extended instr[31:20]; for SRAI this yields 0x400+shamt, which the ALU consumer compensates for.
REQ-021 Load (0000011) SHALL decode as ADD with SrcB = sign-extended I-immediate; store (0100011) SHALL decode as ADD with SrcB = sign-extended S-immediate.
REQ-022 Branch (1100011) SHALL decode as: funct3 000 BEQ, 001 BNE, 100 BLT, 101 BGE, with SrcB = rs2.
REQ-023 LUI (0110111) SHALL decode as LUI with SrcB = {instr[31:12], 12'b0}.
REQ-024 JAL (1101111) and JALR (1100111) SHALL decode as 1111.
REQ-025 Pc4 SHALL be captured as pc+4 for every accepted instruction; pc=508 SHALL wrap to Pc4=0.
REQ-026 Any other opcode/funct combination SHALL register out_valid=1, illegal=1, Operation=0000, SrcA=0, SrcB=0.
REQ-027 SrcA SHALL take rs1_data; SrcB register-sourced operands SHALL take rs2_data.
REQ-028 Forwarding for each source: if exmem_regwrite and exmem_rd==rs and rs!=0, use exmem_result; else if memwb_regwrite and memwb_rd==rs and rs!=0, use memwb_result; else use the register-file data.
REQ-029 When EX/MEM and MEM/WB both match the same source, EX/MEM SHALL win.
REQ-030 When stall=1 and flush=0, all output registers SHALL hold their values and the input instruction SHALL NOT be captured.
REQ-031 When flush=1 (priority over stall), the next cycle SHALL show out_valid=0, illegal=0, Operation=0000, SrcA=0, SrcB=0, Pc4=0.
REQ-032 When in_valid=0 with no stall and no flush, the block SHALL load the same bubble as flush.

Reset
REQ-033 Asserting reset at any time, including mid-stall, SHALL immediately clear SrcA, SrcB, Operation, Pc4, out_valid and illegal to 0.
REQ-034 The first edge after reset release SHALL capture normally.

Verification
REQ-035 add x3,x1,x2 with rs1=5, rs2=7, no forwarding -> next cycle Operation=0100, SrcA=5, SrcB=7, out_valid=1.
REQ-036 srai x5,x6,3 (instr 0x40335293) -> Operation=0111, SrcB=0x403.
REQ-037 rs1=x4 with exmem_rd=4 (result 9) and memwb_rd=4 (result 1), both regwrite -> SrcA=9; the same case with rd=0 -> SrcA=rs1_data.
REQ-038 Instruction held with stall=1 for 3 cycles -> outputs frozen; stall=1 and flush=1 together -> bubble on the next cycle.
REQ-039 jal at pc=508 -> Operation=1111, Pc4=0; opcode 1111111 -> illegal=1, out_valid=1.
REQ-040 Reset asserted between clock edges with out_valid=1 -> all outputs 0 before the next edge.
